// File: rtl/pc_gen_if.sv
// Fetch PC generator bus: redirect/prediction requests in, fetch address and epoch out.
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_RDR = 2,
    parameter int unsigned EPOCH_W = 2
);
    logic                        stall;
    logic [NUM_RDR-1:0]          rdr_valid;
    logic [NUM_RDR*ADDR_W-1:0]   rdr_target;
    logic                        pred_valid;
    logic [ADDR_W-1:0]           pred_target;
    logic [ADDR_W-1:0]           pc;
    logic [ADDR_W-1:0]           npc;
    logic                        pc_valid;
    logic [EPOCH_W-1:0]          epoch;
    logic                        redirect_pending;

    // master: the PC generator itself; slave: the fetch/back-end side
    modport master (
        input  stall, rdr_valid, rdr_target, pred_valid, pred_target,
        output pc, npc, pc_valid, epoch, redirect_pending
    );

    modport slave (
        output stall, rdr_valid, rdr_target, pred_valid, pred_target,
        input  pc, npc, pc_valid, epoch, redirect_pending
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirects, predictor target, stall-safe pending
// redirect and an epoch tag that advances on every accepted redirect.
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       STEP      = 4,
    parameter int unsigned       NUM_RDR   = 2,
    parameter int unsigned       EPOCH_W   = 2
) (
    input  logic       clk,
    input  logic       rst,
    pc_gen_if.master   pcg
);
    localparam int unsigned       IDX_W  = (NUM_RDR > 1) ? $clog2(NUM_RDR) : 1;
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    logic [ADDR_W-1:0]  pc_q, npc_q;
    logic               pc_valid_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               pend_v_q;
    logic [ADDR_W-1:0]  pend_tgt_q;
    logic [IDX_W-1:0]   pend_idx_q;

    logic               rdr_any;
    logic [IDX_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_tgt;
    logic               accept;

    // Scan from highest index down so the lowest set channel is the last assignment.
    always_comb begin
        rdr_any = 1'b0;
        win_idx = '0;
        win_tgt = '0;
        for (int unsigned i = NUM_RDR; i > 0; i--) begin
            if (pcg.rdr_valid[i-1]) begin
                rdr_any = 1'b1;
                win_idx = IDX_W'(i - 1);
                win_tgt = pcg.rdr_target[(i-1)*ADDR_W +: ADDR_W];
            end
        end
        accept = rdr_any && (!pend_v_q || (win_idx <= pend_idx_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            npc_q      <= RESET_VEC + STEP_V;
            pc_valid_q <= 1'b1;
            epoch_q    <= '0;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= '0;
            pend_idx_q <= '0;
        end else begin
            if (accept) begin
                epoch_q <= epoch_q + EPOCH_W'(1);
            end
            if (!pcg.stall) begin
                pc_valid_q <= 1'b1;
                pend_v_q   <= 1'b0;
                if (accept) begin
                    pc_q  <= win_tgt;
                    npc_q <= win_tgt + STEP_V;
                end else if (pend_v_q) begin
                    pc_q  <= pend_tgt_q;
                    npc_q <= pend_tgt_q + STEP_V;
                end else if (pcg.pred_valid) begin
                    pc_q  <= pcg.pred_target;
                    npc_q <= pcg.pred_target + STEP_V;
                end else begin
                    pc_q  <= npc_q;
                    npc_q <= npc_q + STEP_V;
                end
            end else begin
                pc_valid_q <= 1'b0;
                if (accept) begin
                    pend_v_q   <= 1'b1;
                    pend_tgt_q <= win_tgt;
                    pend_idx_q <= win_idx;
                end
            end
        end
    end

    assign pcg.pc               = pc_q;
    assign pcg.npc              = npc_q;
    assign pcg.pc_valid         = pc_valid_q;
    assign pcg.epoch            = epoch_q;
    assign pcg.redirect_pending = pend_v_q;
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch PC generator feeding the instruction-fetch stage; next generation of the single-redirect PC register.
- Arbitrates NUM_RDR prioritised redirect channels (e.g. branch resolve, exception/commit) against a branch-predictor target.
- Holds a pending redirect across stalls without losing it or letting a prediction overwrite it.
- Maintains a fetch epoch tag so downstream stages can squash wrong-path instructions.

Parameters:
- ADDR_W, 32, address width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.
- NUM_RDR, 2, number of redirect channels; channel 0 has highest priority.
- EPOCH_W, 2, epoch counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  fetch cannot accept a new PC this cycle.
- rdr_valid  in  NUM_RDR  per-channel redirect request.
- rdr_target  in  NUM_RDR*ADDR_W  packed targets; channel i occupies bits [i*ADDR_W +: ADDR_W].
- pred_valid  in  1  predictor target valid for the current pc.
- pred_target  in  ADDR_W  predicted next PC.
- pc  out  ADDR_W  current fetch address.
- npc  out  ADDR_W  sequential successor, equal to pc+STEP.
- pc_valid  out  1  pc is a new fetch request this cycle.
- epoch  out  EPOCH_W  epoch tag of pc.
- redirect_pending  out  1  a redirect is latched and not yet applied.

Behaviour:
- Reset (rst=1 at clk edge; overrides every other input that cycle):
  - pc=RESET_VEC, npc=RESET_VEC+STEP, pc_valid=1, epoch=0.
  - Pending register cleared; redirect_pending=0.
- Arithmetic: all additions wrap modulo 2^ADDR_W. Targets pass through unaligned and unchecked.
- Redirect arbitration (combinational):
  - Winner w = lowest index i with rdr_valid[i]=1.
  - "New redirect" exists iff any rdr_valid bit is set.
- Pending register (pend_v, pend_tgt, pend_idx):
  - The new redirect is accepted if pend_v=0 or w<=pend_idx.
  - Otherwise (lower-priority redirect behind a pending higher-priority one) it is discarded.
- Epoch:
  - Increments by 1, wrapping, on every edge where a redirect is accepted, whether stalled or not.
  - An override of a pending redirect also increments it.
  - Predictions never change epoch.
- Update when stall=0, first match wins:
  - 1. Accepted new redirect: pc<=rdr_target[w], npc<=rdr_target[w]+STEP, pend cleared.
  - 2. pend_v=1: pc<=pend_tgt, npc<=pend_tgt+STEP, pend cleared.
  - 3. pred_valid=1: pc<=pred_target, npc<=pred_target+STEP.
  - 4. Otherwise: pc<=npc, npc<=npc+STEP.
  - In all four cases pc_valid<=1.
- Update when stall=1:
  - pc and npc hold; pc_valid<=0.
  - An accepted redirect is written to pend_v/pend_tgt/pend_idx.
  - pred_valid is ignored; the predictor re-presents for the held pc.
- Latency: a redirect seen at edge N appears on pc after edge N, or after the first unstalled edge following N.
- redirect_pending = pend_v, registered.
- Redirect and prediction in the same cycle: redirect wins and the prediction is dropped.
- A prediction is never applied while pend_v=1.
- Reset mid-stall with a redirect pending: the pending redirect is lost and the pc restarts at RESET_VEC.

Test Plan:
- Reset with RESET_VEC=0x100, STEP=4, then 3 unstalled cycles -> pc 0x100, 0x104, 0x108, 0x10C; epoch 0; pc_valid=1 throughout.
- At pc=0x200: pred_valid=1, pred_target=0x400 -> next pc 0x400, npc 0x404, epoch unchanged.
- Pulse rdr_valid[1]=1, target 0x800, under stall held 3 cycles -> pc frozen, pc_valid=0, redirect_pending=1, epoch +1. After stall release: pc=0x800 and redirect_pending=0.
- While pend_idx=1 is stalled, pulse rdr_valid[0] with 0x900 -> epoch +1 again; on release pc=0x900. Reverse order (0 pending, then 1 arrives) -> channel 1 discarded, epoch unchanged, pc=channel-0 target.
- Same cycle: rdr_valid=2'b11 (targets 0xA00/0xB00) with pred_valid=1 -> pc=0xA00 and epoch +1 exactly once.
- Wrap: ADDR_W=32, redirect to 0xFFFFFFFC -> npc=0x00000000 and next sequential pc=0x0. Separately, EPOCH_W=2 with 4 redirects -> epoch returns to 0.
